// File: rtl/mem_access_stage_pkg.sv
// mem_stage_pkg: size encodings, FSM states and lane helpers for the MEM stage
package mem_stage_pkg;
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
      return size == SZ_BYTE ? 4'b0001 << a : size == SZ_HALF ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   endfunction

   // reserved size 2'b11 behaves as a word
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
      return (size == SZ_HALF && a[0]) || (size[1] && a != 2'b00);
   endfunction

   function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] d);
      return size == SZ_BYTE ? {4{d[7:0]}} : size == SZ_HALF ? {2{d[15:0]}} : d;
   endfunction

   function automatic logic [31:0] extract(input logic [1:0] size, input logic [1:0] a,
                                           input logic uns, input logic [31:0] w);
      logic [31:0] sh;
      logic [7:0]  b;
      logic [15:0] h;
      sh = w >> {a, 3'b000};
      b  = sh[7:0];
      h  = a[1] ? w[31:16] : w[15:0];
      return size == SZ_BYTE ? {{24{~uns & b[7]}}, b} :
             size == SZ_HALF ? {{16{~uns & h[15]}}, h} : w;
   endfunction
endpackage

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: EX/MEM-side inputs and MEM/WB-side outputs of the MEM stage
interface mem_access_stage_if;
   logic        valid_in;
   logic        mem_read_in;
   logic        mem_write_in;
   logic [1:0]  size_in;
   logic        unsigned_in;
   logic [31:0] ALU_result_in;
   logic [31:0] write_data_in;
   logic [1:0]  control_wb_in;
   logic [31:0] reg_dst_address_in;
   logic        stall_out;
   logic        valid_out;
   logic [1:0]  control_wb_out;
   logic [31:0] read_data_out;
   logic [31:0] ALU_result_out;
   logic [31:0] reg_dst_address_out;
   logic        misaligned_out;

   modport master (
      output valid_in, mem_read_in, mem_write_in, size_in, unsigned_in,
             ALU_result_in, write_data_in, control_wb_in, reg_dst_address_in,
      input  stall_out, valid_out, control_wb_out, read_data_out,
             ALU_result_out, reg_dst_address_out, misaligned_out
   );

   modport slave (
      input  valid_in, mem_read_in, mem_write_in, size_in, unsigned_in,
             ALU_result_in, write_data_in, control_wb_in, reg_dst_address_in,
      output stall_out, valid_out, control_wb_out, read_data_out,
             ALU_result_out, reg_dst_address_out, misaligned_out
   );
endinterface

// File: rtl/mem_access_stage_data_ram.sv
// data_ram: single-port 32-bit RAM with byte-enable write and registered read
module data_ram #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  CLK,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  we,
   input  logic [3:0]            be,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);
   logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

   // byte-lane write and read of the addressed word; contents are never reset
   always_ff @(posedge CLK) begin
      for (int i = 0; i < 4; i++)
         if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      rdata <= mem[addr];
   end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline MEM stage with multi-cycle data RAM and upstream stall
module mem_access_stage
   import mem_stage_pkg::*;
#(
   parameter int ADDR_WIDTH  = 10,
   parameter int MEM_LATENCY = 2
) (
   input logic               CLK,
   input logic               RESET_N,
   mem_access_stage_if.slave bus
);
   state_t                state, state_nx;
   logic [2:0]            cnt;
   logic [31:0]           h_addr, h_wdata, h_dst;
   logic [1:0]            h_size, h_wb;
   logic                  h_uns, h_load, h_store;
   logic [31:0]           rdata;
   logic                  accept, is_mem, mis, go_wait, last, ram_we;
   logic [ADDR_WIDTH-1:0] ram_addr;

   // acceptance decode, next state and RAM control
   always_comb begin
      accept   = state != WAIT && bus.valid_in;
      is_mem   = bus.mem_read_in | bus.mem_write_in;
      mis      = is_mem & misaligned(bus.size_in, bus.ALU_result_in[1:0]);
      go_wait  = accept && is_mem && !mis;
      last     = state == WAIT && cnt == '0;
      state_nx = state == WAIT ? (cnt == '0 ? DONE : WAIT) : (go_wait ? WAIT : IDLE);
      ram_we   = last && h_store;
      ram_addr = state == WAIT ? h_addr[ADDR_WIDTH+1:2] : bus.ALU_result_in[ADDR_WIDTH+1:2];
   end

   // state register
   always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N) state <= IDLE;
      else          state <= state_nx;

   // holding registers, wait counter and registered outputs
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         cnt                     <= '0;
         h_addr                  <= '0;
         h_wdata                 <= '0;
         h_dst                   <= '0;
         h_size                  <= '0;
         h_wb                    <= '0;
         h_uns                   <= 1'b0;
         h_load                  <= 1'b0;
         h_store                 <= 1'b0;
         bus.stall_out           <= 1'b0;
         bus.valid_out           <= 1'b0;
         bus.control_wb_out      <= '0;
         bus.read_data_out       <= '0;
         bus.ALU_result_out      <= '0;
         bus.reg_dst_address_out <= '0;
         bus.misaligned_out      <= 1'b0;
      end else begin
         if (accept) begin
            h_addr  <= bus.ALU_result_in;
            h_wdata <= bus.write_data_in;
            h_dst   <= bus.reg_dst_address_in;
            h_size  <= bus.size_in;
            h_wb    <= bus.control_wb_in;
            h_uns   <= bus.unsigned_in;
            h_load  <= bus.mem_read_in;
            h_store <= bus.mem_write_in & ~bus.mem_read_in;
         end
         cnt           <= go_wait ? 3'(MEM_LATENCY - 1) : state == WAIT ? cnt - 3'd1 : cnt;
         bus.stall_out <= state_nx == WAIT;
         bus.valid_out <= last || (accept && !go_wait);
         if (last) begin
            bus.ALU_result_out      <= h_addr;
            bus.reg_dst_address_out <= h_dst;
            bus.control_wb_out      <= h_wb;
            bus.misaligned_out      <= 1'b0;
            bus.read_data_out       <= h_load ? extract(h_size, h_addr[1:0], h_uns, rdata) : '0;
         end else if (accept && !go_wait) begin
            bus.ALU_result_out      <= bus.ALU_result_in;
            bus.reg_dst_address_out <= bus.reg_dst_address_in;
            bus.control_wb_out      <= mis ? 2'b00 : bus.control_wb_in;
            bus.misaligned_out      <= mis;
            bus.read_data_out       <= '0;
         end
      end
   end

   data_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
      .CLK   (CLK),
      .addr  (ram_addr),
      .we    (ram_we),
      .be    (byte_en(h_size, h_addr[1:0])),
      .wdata (replicate(h_size, h_wdata)),
      .rdata (rdata)
   );
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed and random checks against a byte-addressed memory model
module tb_mem_access_stage;
   localparam int AW  = 10;
   localparam int LAT = 2;

   logic CLK     = 1'b0;
   logic RESET_N = 1'b0;
   int   total   = 0;
   int   bad     = 0;
   logic [7:0] bmem [0:4095];

   mem_access_stage_if bus();

   mem_access_stage #(.ADDR_WIDTH(AW), .MEM_LATENCY(LAT)) dut (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .bus     (bus)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] wb, input logic [31:0] dst);
      bus.valid_in           = v;
      bus.mem_read_in        = rd;
      bus.mem_write_in       = wr;
      bus.size_in            = sz;
      bus.unsigned_in        = uns;
      bus.ALU_result_in      = a;
      bus.write_data_in      = wd;
      bus.control_wb_in      = wb;
      bus.reg_dst_address_in = dst;
   endtask

   task automatic scramble();
      drive(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
            $urandom, $urandom, 2'($urandom), $urandom);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "/stall"}, 32'(bus.stall_out), 0);
      chk({tag, "/valid"}, 32'(bus.valid_out), 0);
      chk({tag, "/mis"}, 32'(bus.misaligned_out), 0);
      chk({tag, "/wb"}, 32'(bus.control_wb_out), 0);
      chk({tag, "/rd"}, bus.read_data_out, 0);
      chk({tag, "/alu"}, bus.ALU_result_out, 0);
      chk({tag, "/dst"}, bus.reg_dst_address_out, 0);
   endtask

   // issue one instruction, follow it to completion and compare with the model
   task automatic run_op(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] wb, input logic [31:0] dst);
      int          n, lat, got;
      logic        mem, mis;
      logic [11:0] idx;
      logic [31:0] exp_rd;
      n      = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
      mem    = rd | wr;
      mis    = mem && (a % n != 0);
      exp_rd = 0;
      if (mem && !mis) begin
         for (int i = 0; i < n; i++) begin
            idx = 12'(a + i);
            if (rd) exp_rd |= 32'(bmem[idx]) << (8 * i);
            else    bmem[idx] = wd[8*i +: 8];
         end
         if (rd && !uns && n < 4 && exp_rd[8*n-1]) exp_rd |= ~((32'd1 << (8 * n)) - 32'd1);
      end
      lat = (mem && !mis) ? LAT + 1 : 1;
      drive(1'b1, rd, wr, sz, uns, a, wd, wb, dst);
      tick();
      got = 1;
      while (!bus.valid_out && got < 20) begin
         chk({tag, "/busy"}, 32'(bus.stall_out), 1);
         scramble();
         tick();
         got++;
      end
      bus.valid_in = 1'b0;
      chk({tag, "/lat"}, got, lat);
      chk({tag, "/stall"}, 32'(bus.stall_out), 0);
      chk({tag, "/mis"}, 32'(bus.misaligned_out), 32'(mis));
      chk({tag, "/wb"}, 32'(bus.control_wb_out), mis ? 0 : 32'(wb));
      chk({tag, "/rd"}, bus.read_data_out, exp_rd);
      chk({tag, "/alu"}, bus.ALU_result_out, a);
      chk({tag, "/dst"}, bus.reg_dst_address_out, dst);
   endtask

   initial begin
      logic [31:0] a;
      int          k;
      drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 0, 0, 2'd0, 0);
      tick();
      tick();
      chk_zero("reset");
      RESET_N = 1'b1;
      tick();
      chk_zero("post_reset");

      for (int w = 0; w <= 'h84; w += 4)
         run_op("init", 1'b0, 1'b1, 2'd2, 1'b0, w, $urandom, 2'd0, 0);

      run_op("nonmem", 1'b0, 1'b0, 2'd0, 1'b0, 32'h1234, 0, 2'b10, 5);
      run_op("st_w40", 1'b0, 1'b1, 2'd2, 1'b0, 32'h40, 32'hDEADBEEF, 2'b01, 3);
      run_op("ld_w40", 1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 0, 2'b11, 7);
      run_op("st_b43", 1'b0, 1'b1, 2'd0, 1'b0, 32'h43, 32'h80, 2'b00, 0);
      run_op("ld_b43s", 1'b1, 1'b0, 2'd0, 1'b0, 32'h43, 0, 2'b11, 8);
      run_op("ld_b43u", 1'b1, 1'b0, 2'd0, 1'b1, 32'h43, 0, 2'b11, 9);
      run_op("ld_w40b", 1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 0, 2'b11, 10);
      run_op("ld_h41", 1'b1, 1'b0, 2'd1, 1'b0, 32'h41, 0, 2'b11, 11);
      run_op("ld_w40c", 1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 0, 2'b11, 12);

      run_op("st_w80", 1'b0, 1'b1, 2'd2, 1'b0, 32'h80, 32'hCAFEF00D, 2'b01, 0);
      drive(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 32'h80, 32'h11111111, 2'b01, 0);
      tick();
      chk("abort/wait_stall", 32'(bus.stall_out), 1);
      drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 0, 0, 2'd0, 0);
      RESET_N = 1'b0;
      #1;
      chk_zero("abort");
      tick();
      tick();
      RESET_N = 1'b1;
      tick();
      chk_zero("abort_after");
      run_op("ld_w80", 1'b1, 1'b0, 2'd2, 1'b0, 32'h80, 0, 2'b11, 13);

      run_op("st_wrap", 1'b0, 1'b1, 2'd2, 1'b0, 32'h1008, 32'h5A5AA5A5, 2'b01, 0);
      run_op("ld_wrap", 1'b1, 1'b0, 2'd2, 1'b0, 32'h8, 0, 2'b11, 14);

      for (int i = 0; i < 200; i++) begin
         a = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63));
         k = $urandom_range(0, 2);
         run_op("rand", k == 1, k == 2, 2'($urandom), 1'($urandom), a, $urandom,
                2'($urandom), $urandom);
         if ($urandom_range(0, 3) == 0) begin
            tick();
            chk("idle/valid", 32'(bus.valid_out), 0);
            chk("idle/stall", 32'(bus.stall_out), 0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Pipeline MEM stage: sits between the EX/MEM register and the MEM/WB register, which it feeds directly.
- Performs loads and stores against an internal word-organised data RAM, with byte, halfword and word sizing and sign or zero extension on loads.
- Memory has a fixed multi-cycle latency; the stage stalls the upstream pipeline while an access is in flight.
- Registers ALU result, writeback control and destination for the downstream register.

Parameters:
- ADDR_WIDTH, 10, word-address width of the data RAM (2^ADDR_WIDTH 32-bit words).
- MEM_LATENCY, 2, wait cycles per memory access; legal range 1..7.

Ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- valid_in  in  1  an instruction is presented this cycle.
- mem_read_in  in  1  instruction is a load.
- mem_write_in  in  1  instruction is a store; mem_read_in and mem_write_in both 1 is illegal.
- size_in  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- unsigned_in  in  1  load zero-extends when 1, sign-extends when 0.
- ALU_result_in  in  32  effective address, or the result for non-memory instructions.
- write_data_in  in  32  store data; low bits hold the value.
- control_wb_in  in  2  writeback control, passed through.
- reg_dst_address_in  in  32  destination register, passed through.
- stall_out  out  1  upstream must hold all inputs and not advance.
- valid_out  out  1  outputs hold a completed instruction this cycle.
- control_wb_out  out  2  writeback control; forced 00 on a misaligned access.
- read_data_out  out  32  extended load data; 0 for non-loads.
- ALU_result_out  out  32  registered copy of ALU_result_in.
- reg_dst_address_out  out  32  registered copy of reg_dst_address_in.
- misaligned_out  out  1  the completed access was misaligned.

Behaviour:
- Reset is asynchronous, active-low, single clock CLK; this is fixed.
- While RESET_N=0: FSM goes to IDLE; stall_out, valid_out and misaligned_out are 0; all data and control outputs are 0.
- RAM contents are not reset.
- FSM has three states: IDLE, WAIT, DONE. All outputs are registered.
- IDLE, valid_in=0: valid_out=0 next cycle.
- IDLE, valid_in=1, non-memory instruction: captured; valid_out=1 on the next edge (1-cycle latency); stall_out stays 0.
- IDLE, valid_in=1, memory op, misaligned: misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
  - Completes in 1 cycle with no RAM access and no stall.
  - misaligned_out=1, control_wb_out=00, read_data_out=0.
- IDLE, valid_in=1, aligned memory op: inputs are captured into internal holding registers. Go to WAIT with stall_out=1 and a counter loaded with MEM_LATENCY-1.
- WAIT: the counter decrements each cycle. At 0, go to DONE.
  - A store is committed to RAM on this transition, with byte enables derived from size and addr[1:0]. Data is replicated to the selected lanes.
  - A load's RAM data is read on this transition.
- DONE: valid_out=1 for exactly one cycle and stall_out drops to 0 in the same cycle, then return to IDLE.
  - A new valid_in is accepted in the DONE cycle, giving back-to-back operation.
- Latency: aligned memory op is MEM_LATENCY+1 cycles from acceptance to valid_out.
- Load extraction: the lane is selected by addr[1:0] (byte) or addr[1] (half), little-endian. It is then sign- or zero-extended to 32 bits.
- Address mapping: word index = addr[ADDR_WIDTH+1:2]. Upper bits are ignored, so addresses wrap modulo the RAM size.
- Inputs are ignored while stall_out=1; the captured copy is used.
- A reset asserted during WAIT aborts the access: the store is not committed and no valid_out is produced.
- mem_read_in and mem_write_in both 1: treated as a load. Verification may flag this with an assertion.

Decomposition:
- Package mem_stage_pkg holds:
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD);
  - the FSM state enum;
  - a function computing the byte-enable mask from size and addr[1:0].
- One sub-module: data_ram. It is a synchronous single-port RAM, 2^ADDR_WIDTH x 32, with a 4-bit byte-enable write and registered read.

Test Plan:
- Reset: hold RESET_N=0, then release. All outputs are 0, stall_out=0.
- Non-memory instruction with ALU_result_in=0x1234, reg_dst=5, wb=10. valid_out=1 one cycle later carrying the same values, read_data_out=0, no stall.
- Store word 0xDEADBEEF to 0x40, then load word from 0x40. stall_out is high for 2 cycles per access and read_data_out=0xDEADBEEF, 3 cycles after load acceptance.
- Store byte 0x80 to 0x43, then load byte signed and then unsigned from 0x43. Results are 0xFFFFFF80 and 0x00000080; the other bytes of word 0x40 are unchanged.
- Load half from 0x41. Completes in 1 cycle, misaligned_out=1, control_wb_out=00, no stall, RAM unchanged.
- Store word 0x11111111 to 0x80 and assert RESET_N=0 in the first WAIT cycle. After reset, load 0x80 returns the prior contents, not 0x11111111.
- Address wrap: store to 0x1000+0x8 with ADDR_WIDTH=10. Load from 0x8 returns the stored value.
